// File: rtl/mem_request_scheduler.sv
// mem_request_scheduler: round-robin sequencing of per-stream buffers
// into bounded, boundary-aligned memory transfer requests.
module mem_request_scheduler #(
    parameter int NUM_STREAMS        = 4,
    parameter int VADDR_BITS         = 48,
    parameter int SIZE_BITS          = 32,
    parameter int MAX_TRANSFER_BYTES = 4096,
    parameter int LEN_BITS           = $clog2(MAX_TRANSFER_BYTES) + 1,
    parameter int STREAM_BITS        = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_STREAMS-1:0]              buf_valid,
    output logic [NUM_STREAMS-1:0]              buf_ready,
    input  logic [NUM_STREAMS*VADDR_BITS-1:0]   buf_vaddr,
    input  logic [NUM_STREAMS*SIZE_BITS-1:0]    buf_size,
    output logic                                req_valid,
    input  logic                                req_ready,
    output logic [STREAM_BITS-1:0]              req_stream,
    output logic [VADDR_BITS-1:0]               req_vaddr,
    output logic [LEN_BITS-1:0]                 req_len,
    output logic                                req_last,
    output logic [NUM_STREAMS-1:0]              buf_done
);

    localparam int CW = SIZE_BITS + 1;
    localparam logic [CW-1:0] MAX_C  = CW'(MAX_TRANSFER_BYTES);
    localparam logic [CW-1:0] MASK_C = CW'(MAX_TRANSFER_BYTES - 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                  state_q;
    logic [NUM_STREAMS-1:0]  active_q;
    logic [VADDR_BITS-1:0]   vaddr_q [NUM_STREAMS];
    logic [SIZE_BITS-1:0]    rem_q   [NUM_STREAMS];
    logic [NUM_STREAMS-1:0]  done_q;
    logic [STREAM_BITS-1:0]  rr_ptr_q;
    logic [STREAM_BITS-1:0]  rr_ptr_d;

    logic                    req_valid_q;
    logic [STREAM_BITS-1:0]  req_stream_q;
    logic [VADDR_BITS-1:0]   req_vaddr_q;
    logic [LEN_BITS-1:0]     req_len_q;
    logic                    req_last_q;

    logic                    grant_found;
    logic [STREAM_BITS-1:0]  grant_sel;
    logic [VADDR_BITS-1:0]   sel_vaddr;
    logic [CW-1:0]           sel_rem;
    logic [CW-1:0]           room;
    logic [CW-1:0]           chunk;
    logic                    hs;

    assign buf_ready  = ~active_q;
    assign buf_done   = done_q;
    assign req_valid  = req_valid_q;
    assign req_stream = req_stream_q;
    assign req_vaddr  = req_vaddr_q;
    assign req_len    = req_len_q;
    assign req_last   = req_last_q;

    assign hs = (state_q == ISSUE) && req_valid_q && req_ready;

    // Round-robin pick: first active stream at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_sel   = '0;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_STREAMS;
            if (!grant_found && active_q[idx]) begin
                grant_found = 1'b1;
                grant_sel   = STREAM_BITS'(idx);
            end
        end
    end

    // Chunk sizing: stop at the remaining bytes or the next aligned boundary.
    always_comb begin
        sel_vaddr = vaddr_q[grant_sel];
        sel_rem   = CW'(rem_q[grant_sel]);
        room      = MAX_C - (CW'(sel_vaddr) & MASK_C);
        chunk     = (sel_rem < room) ? sel_rem : room;
    end

    // Pointer moves one past the stream that was just served.
    always_comb begin
        if (int'(req_stream_q) == NUM_STREAMS - 1) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = req_stream_q + STREAM_BITS'(1);
        end
    end

    // Stream slots: accept new buffers, advance on handshake, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= '0;
            done_q   <= '0;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                vaddr_q[i] <= '0;
                rem_q[i]   <= '0;
            end
        end else begin
            done_q <= '0;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                if (buf_valid[i] && !active_q[i]) begin
                    if (buf_size[i*SIZE_BITS +: SIZE_BITS] != '0) begin
                        active_q[i] <= 1'b1;
                        vaddr_q[i]  <= buf_vaddr[i*VADDR_BITS +: VADDR_BITS];
                        rem_q[i]    <= buf_size[i*SIZE_BITS +: SIZE_BITS];
                    end else begin
                        done_q[i] <= 1'b1;
                    end
                end
            end
            if (hs) begin
                vaddr_q[req_stream_q] <= vaddr_q[req_stream_q]
                                         + VADDR_BITS'(req_len_q);
                rem_q[req_stream_q]   <= rem_q[req_stream_q]
                                         - SIZE_BITS'(req_len_q);
                if (req_last_q) begin
                    active_q[req_stream_q] <= 1'b0;
                    done_q[req_stream_q]   <= 1'b1;
                end
            end
        end
    end

    // Request FSM: load a chunk in IDLE, hold it in ISSUE until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            req_valid_q  <= 1'b0;
            req_stream_q <= '0;
            req_vaddr_q  <= '0;
            req_len_q    <= '0;
            req_last_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        req_stream_q <= grant_sel;
                        req_vaddr_q  <= sel_vaddr;
                        req_len_q    <= LEN_BITS'(chunk);
                        req_last_q   <= (sel_rem == chunk);
                        req_valid_q  <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (req_ready) begin
                        req_valid_q <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_scheduler.sv
// tb_mem_request_scheduler: directed checks of chunking, arbitration,
// backpressure, zero-size buffers and mid-transfer reset.
module tb_mem_request_scheduler;

    localparam int N   = 4;
    localparam int VA  = 48;
    localparam int SB  = 32;
    localparam int LB  = 13;
    localparam int STB = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      buf_valid;
    logic [N-1:0]      buf_ready;
    logic [N*VA-1:0]   buf_vaddr;
    logic [N*SB-1:0]   buf_size;
    logic              req_valid;
    logic              req_ready;
    logic [STB-1:0]    req_stream;
    logic [VA-1:0]     req_vaddr;
    logic [LB-1:0]     req_len;
    logic              req_last;
    logic [N-1:0]      buf_done;

    int n_cmp = 0;
    int n_bad = 0;

    mem_request_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .buf_valid  (buf_valid),
        .buf_ready  (buf_ready),
        .buf_vaddr  (buf_vaddr),
        .buf_size   (buf_size),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_stream (req_stream),
        .req_vaddr  (req_vaddr),
        .req_len    (req_len),
        .req_last   (req_last),
        .buf_done   (buf_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_buf(input int i, input logic [VA-1:0] va,
                           input logic [SB-1:0] sz);
        buf_valid[i]         = 1'b1;
        buf_vaddr[i*VA +: VA] = va;
        buf_size[i*SB +: SB]  = sz;
    endtask

    task automatic wait_req();
        for (int c = 0; c < 20; c++) begin
            if (req_valid) break;
            tick();
        end
        chk("req_valid_wait", 64'(req_valid), 64'd1);
    endtask

    task automatic expect_req(input string tag, input int s,
                              input logic [VA-1:0] va, input int len,
                              input logic last);
        wait_req();
        chk({tag, "_stream"}, 64'(req_stream), 64'(s));
        chk({tag, "_vaddr"},  64'(req_vaddr),  64'(va));
        chk({tag, "_len"},    64'(req_len),    64'(len));
        chk({tag, "_last"},   64'(req_last),   64'(last));
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        buf_valid = '0;
        buf_vaddr = '0;
        buf_size  = '0;
        req_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_req_stream", 64'(req_stream), 64'd0);
        chk("rst_req_vaddr", 64'(req_vaddr), 64'd0);
        chk("rst_req_len", 64'(req_len), 64'd0);
        chk("rst_req_last", 64'(req_last), 64'd0);
        chk("rst_buf_ready", 64'(buf_ready), 64'hF);
        chk("rst_buf_done", 64'(buf_done), 64'd0);

        // single stream, three chunks
        set_buf(0, 48'h1000, 32'h2800);
        tick();
        buf_valid = '0;
        chk("lat_t1_valid", 64'(req_valid), 64'd0);
        chk("lat_t1_ready0", 64'(buf_ready[0]), 64'd0);
        tick();
        chk("lat_t2_valid", 64'(req_valid), 64'd1);
        expect_req("s0c0", 0, 48'h1000, 4096, 1'b0);
        chk("s0_no_done", 64'(buf_done), 64'd0);
        expect_req("s0c1", 0, 48'h2000, 4096, 1'b0);
        expect_req("s0c2", 0, 48'h3000, 2048, 1'b1);
        chk("s0_done", 64'(buf_done), 64'h1);
        chk("s0_ready", 64'(buf_ready), 64'hF);
        tick();
        chk("s0_done_clr", 64'(buf_done), 64'd0);

        // unaligned start crosses one boundary
        set_buf(1, 48'h0F00, 32'h300);
        tick();
        buf_valid = '0;
        expect_req("ua0", 1, 48'h0F00, 32'h100, 1'b0);
        expect_req("ua1", 1, 48'h1000, 32'h200, 1'b1);
        chk("ua_done", 64'(buf_done), 64'h2);

        // reset to put the pointer at 0, then four streams round robin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_buf(i, VA'((i + 1) * 32'h10000), 32'h2000);
        tick();
        buf_valid = '0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                expect_req($sformatf("rr%0d_%0d", r, i), i,
                           VA'((i + 1) * 32'h10000 + r * 32'h1000),
                           4096, r == 1);
            end
        end
        chk("rr_ready", 64'(buf_ready), 64'hF);

        // backpressure holds the request stable
        req_ready = 1'b0;
        set_buf(3, 48'h5000, 32'h1000);
        tick();
        buf_valid = '0;
        wait_req();
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid", 64'(req_valid), 64'd1);
            chk("bp_vaddr", 64'(req_vaddr), 64'h5000);
            chk("bp_len", 64'(req_len), 64'd4096);
            chk("bp_stream", 64'(req_stream), 64'd3);
            chk("bp_busy", 64'(buf_ready), 64'h7);
            tick();
        end
        req_ready = 1'b1;
        tick();
        chk("bp_hs_done", 64'(buf_done), 64'h8);
        chk("bp_hs_valid", 64'(req_valid), 64'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("bp_single", 64'(req_valid), 64'd0);
        end

        // zero-size buffer on stream 2
        set_buf(2, 48'h7000, 32'h0);
        tick();
        buf_valid = '0;
        chk("zs_done", 64'(buf_done), 64'h4);
        chk("zs_ready", 64'(buf_ready), 64'hF);
        tick();
        chk("zs_done_clr", 64'(buf_done), 64'd0);
        chk("zs_no_req", 64'(req_valid), 64'd0);
        tick();
        chk("zs_no_req2", 64'(req_valid), 64'd0);

        // reset mid-transfer, then reload stream 0
        req_ready = 1'b0;
        set_buf(0, 48'h1000, 32'h2000);
        tick();
        buf_valid = '0;
        wait_req();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_valid", 64'(req_valid), 64'd0);
        chk("mr_ready", 64'(buf_ready), 64'hF);
        chk("mr_done", 64'(buf_done), 64'd0);
        req_ready = 1'b1;
        set_buf(0, 48'h8000, 32'h100);
        tick();
        buf_valid = '0;
        expect_req("mr_new", 0, 48'h8000, 32'h100, 1'b1);
        chk("mr_new_done", 64'(buf_done), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
